// File: rtl/cv32e40p_obi_mem_responder.sv
// cv32e40p_obi_mem_responder
// OBI responder for a cv32e40p instruction or data port, backed by a
// word-addressed, byte-enabled memory. Responses come back in order, exactly
// RESP_LATENCY cycles after their grant, with up to MAX_OUTSTANDING in flight.
//
// Handshake: a request transfers in any cycle where req_i && gnt_o. The
// initiator holds addr/we/be/wdata stable while req_i is high and gnt_o low.
// rvalid_o pulses for exactly one cycle per granted request; there is no
// response backpressure.
//
// Optional feature: define CV32E40P_OBI_RESP_STALL_EN to withhold grants
// pseudo-randomly (LFSR[2:0] == 0) without changing response latency.
module cv32e40p_obi_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned IW = $clog2(MEM_WORDS);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned LW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

    localparam logic [32:0]    MEM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [LW-1:0]  CNT_INIT  = LW'(RESP_LATENCY - 1);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(MAX_OUTSTANDING);
    localparam logic [31:0]    MISS_DATA = 32'hDEAD_BEEF;

    // Backing store: not reset, contents undefined until written.
    logic [31:0] mem [MEM_WORDS];

    // Response queue: each slot holds its data and cycles left until it is due.
    logic [31:0]   q_data [MAX_OUTSTANDING];
    logic [LW-1:0] q_cnt  [MAX_OUTSTANDING];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;

    logic [31:0]   offset;
    logic          hit;
    logic [IW-1:0] word_idx;
    logic          stall;
    logic          accept;
    logic [31:0]   resp_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Address decode relative to the window base; addresses below the base
    // wrap to large offsets and therefore miss.
    assign offset   = addr_i - BASE_ADDR;
    assign hit      = ({1'b0, offset} < MEM_BYTES);
    assign word_idx = offset[IW+1:2];

    // The head slot is presented once its countdown has expired.
    assign rvalid_o        = (count != '0) && (q_cnt[rd_ptr] == '0);
    assign rdata_o         = rvalid_o ? q_data[rd_ptr] : '0;
    assign count_after_pop = count - CW'(rvalid_o);

    // A slot freed by this cycle's response can be refilled in the same cycle.
    assign gnt_o  = req_i && !rst_i && (count_after_pop < CNT_MAX) && !stall;
    assign accept = req_i && gnt_o;

`ifdef CV32E40P_OBI_RESP_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign stall   = (lfsr[2:0] == 3'b000);

    // Fibonacci LFSR (taps 16,14,13,11) stepping every cycle out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Response payload captured at accept: writes answer 0, misses DEADBEEF.
    always_comb begin
        resp_data = '0;
        if (!we_i) begin
            resp_data = hit ? mem[word_idx] : MISS_DATA;
        end
    end

    // Byte-enabled memory write on an accepted write hit.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response queue: count down all slots, push on accept, pop on rvalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_cnt[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (q_cnt[i] != '0) begin
                    q_cnt[i] <= q_cnt[i] - LW'(1);
                end
            end
            if (accept) begin
                q_cnt[wr_ptr]  <= CNT_INIT;
                q_data[wr_ptr] <= resp_data;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (rvalid_o) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(accept) - CW'(rvalid_o);
        end
    end

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for cv32e40p_obi_mem_responder. Two instances share clock and reset:
// index 0 uses RESP_LATENCY=1, index 1 uses RESP_LATENCY=4; both allow two
// outstanding responses. A reference model per instance predicts grants,
// response timing and data from the address map and latency rules.
// Honours CV32E40P_OBI_RESP_STALL_EN when it is defined for the build.
module tb_cv32e40p_obi_mem_responder;

    localparam int          WORDS_A = 1024;
    localparam logic [31:0] BASE_A  = 32'h0001_0000;
    localparam int          LAT_A   = 1;
    localparam int          WORDS_B = 64;
    localparam logic [31:0] BASE_B  = 32'h2000_0000;
    localparam int          LAT_B   = 4;
    localparam int          MAXO    = 2;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    logic [31:0] last_rd  [2];
    int          n_rsp_m  [2];
    int          n_rv_obs [2];
    int          gcyc_b[$];
    int          rcyc_b[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    cv32e40p_obi_mem_responder #(
        .MEM_WORDS(WORDS_A), .BASE_ADDR(BASE_A),
        .RESP_LATENCY(LAT_A), .MAX_OUTSTANDING(MAXO)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
    );

    cv32e40p_obi_mem_responder #(
        .MEM_WORDS(WORDS_B), .BASE_ADDR(BASE_B),
        .RESP_LATENCY(LAT_B), .MAX_OUTSTANDING(MAXO)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- stall model ----------------
    logic stall_m;
`ifdef CV32E40P_OBI_RESP_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= (lfsr_m >> 1) |
                           (16'(lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5]) << 15);
    end
    assign stall_m = (lfsr_m[2:0] == 3'd0);
`else
    assign stall_m = 1'b0;
`endif

    // ---------------- reference model + scoreboard ----------------
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam logic [31:0] BASE  = (g == 0) ? BASE_A : BASE_B;
        localparam longint      BYTES = longint'((g == 0) ? WORDS_A : WORDS_B) * 4;
        localparam int          LAT   = (g == 0) ? LAT_A : LAT_B;

        logic [31:0] mm [int];
        int          due_q[$];
        logic [31:0] exp_q[$];
        bit          chk_q[$];

        always @(negedge clk) begin : step
            bit          pop;
            bit          eg;
            bit          hit;
            bit          c;
            logic [31:0] off;
            logic [31:0] d;
            int          idx;
            if (rst) begin
                check($sformatf("rst_gnt%0d", g), 32'(gnt[g]), 32'd0);
                check($sformatf("rst_rvalid%0d", g), 32'(rvalid[g]), 32'd0);
                check($sformatf("rst_rdata%0d", g), rdata[g], 32'd0);
                due_q.delete();
                exp_q.delete();
                chk_q.delete();
            end else begin
                pop = (due_q.size() != 0) && (due_q[0] == cyc);
                eg  = req[g] && ((due_q.size() - int'(pop)) < MAXO) && !stall_m;
                check($sformatf("gnt%0d", g), 32'(gnt[g]), 32'(eg));
                check($sformatf("rvalid%0d", g), 32'(rvalid[g]), 32'(pop));
                if (rvalid[g]) begin
                    n_rv_obs[g]++;
                    if (g == 1) rcyc_b.push_back(cyc);
                end
                if (pop) begin
                    if (chk_q[0]) check($sformatf("rdata%0d", g), rdata[g], exp_q[0]);
                    last_rd[g] = rdata[g];
                    n_rsp_m[g]++;
                    due_q.delete(0);
                    exp_q.delete(0);
                    chk_q.delete(0);
                end else begin
                    check($sformatf("rdata_idle%0d", g), rdata[g], 32'd0);
                end
                if (eg) begin
                    off = addr[g] - BASE;
                    hit = (longint'(off) < BYTES);
                    idx = int'(off >> 2);
                    if (we[g]) begin
                        d = 32'h0;
                        c = 1'b1;
                        if (hit) begin
                            logic [31:0] cur;
                            cur = mm.exists(idx) ? mm[idx] : 32'hx;
                            for (int b = 0; b < 4; b++)
                                if (be[g][b]) cur[8*b +: 8] = wdata[g][8*b +: 8];
                            mm[idx] = cur;
                        end
                    end else if (hit) begin
                        d = mm.exists(idx) ? mm[idx] : 32'hx;
                        c = !$isunknown(d);
                    end else begin
                        d = 32'hDEAD_BEEF;
                        c = 1'b1;
                    end
                    due_q.push_back(cyc + LAT);
                    exp_q.push_back(d);
                    chk_q.push_back(c);
                    if (g == 1) gcyc_b.push_back(cyc);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? BASE_A : BASE_B;
    endfunction

    function automatic logic [31:0] bytes_of(input int i);
        return (i == 0) ? 32'(WORDS_A * 4) : 32'(WORDS_B * 4);
    endfunction

    // Call just after a rising edge; returns just after the edge ending the
    // grant cycle, with req dropped.
    task automatic issue(input int i, input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        int waited;
        waited   = 0;
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        be[i]    = b;
        wdata[i] = d;
        @(negedge clk);
        while (!gnt[i] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!gnt[i]) check($sformatf("gnt_timeout%0d", i), 32'(gnt[i]), 32'd1);
        @(posedge clk);
        #1;
        req[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            int          sel;
            int          gap;
            sel = $urandom_range(0, 7);
            if (sel == 0)      a = base_of(i) + bytes_of(i) + 4 * $urandom_range(0, 3);
            else if (sel == 1) a = base_of(i) - 4;
            else               a = base_of(i) + 4 * $urandom_range(0, 15);
            a[1:0] = 2'($urandom_range(0, 3));
            issue(i, ($urandom_range(0, 2) == 0), a, 4'($urandom_range(0, 15)), $urandom);
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
        end
    endtask

    // ---------------- test sequence ----------------
    int          t0;
    logic [31:0] fq_vals [6];
    int          g_exp   [4];
    int          r_exp   [4];

    initial begin
        g_exp = '{0, 1, 4, 5};
        r_exp = '{4, 5, 8, 9};
        n_rsp_m  = '{0, 0};
        n_rv_obs = '{0, 0};
        last_rd  = '{32'h0, 32'h0};
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        be    = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1 req = 2'b11;
        @(posedge clk);
        #2 rst = 1'b0;
        req = '0;
        idle(1);

        // Give the first 16 words of both memories known contents.
        fork
            for (int k = 0; k < 16; k++) issue(0, 1'b1, BASE_A + 32'(4 * k), 4'hF, $urandom);
            for (int k = 0; k < 16; k++) begin
                logic [31:0] v;
                v = $urandom;
                if (k < 6) fq_vals[k] = v;
                issue(1, 1'b1, BASE_B + 32'(4 * k), 4'hF, v);
            end
        join
        idle(6);

        // Write then read, latency 1.
        issue(0, 1'b1, BASE_A + 32'h10, 4'hF, 32'hCAFE_F00D);
        issue(0, 1'b0, BASE_A + 32'h10, 4'h0, 32'h0);
        idle(2);
        check("wr_rd", last_rd[0], 32'hCAFE_F00D);

        // Byte enables.
        issue(0, 1'b1, BASE_A + 32'h20, 4'hF, 32'h1122_3344);
        issue(0, 1'b1, BASE_A + 32'h20, 4'b0101, 32'hAABB_CCDD);
        issue(0, 1'b0, BASE_A + 32'h20, 4'h0, 32'h0);
        idle(2);
        check("byte_en", last_rd[0], 32'h11BB_33DD);

        // Miss: first byte past the window, then a dropped write to it.
        issue(0, 1'b0, BASE_A + 32'(WORDS_A * 4), 4'h0, 32'h0);
        idle(2);
        check("miss_rd", last_rd[0], 32'hDEAD_BEEF);
        issue(0, 1'b1, BASE_A + 32'(WORDS_A * 4), 4'hF, 32'h1234_5678);
        issue(0, 1'b0, BASE_A + 32'(WORDS_A * 4), 4'h0, 32'h0);
        idle(2);
        check("miss_wr_rd", last_rd[0], 32'hDEAD_BEEF);

        // Full queue on the latency-4 instance: req held for six reads.
        gcyc_b.delete();
        rcyc_b.delete();
        t0 = cyc;
        for (int k = 0; k < 6; k++) issue(1, 1'b0, BASE_B + 32'(4 * k), 4'h0, 32'h0);
        idle(8);
        check("fq_last_data", last_rd[1], fq_vals[5]);
`ifndef CV32E40P_OBI_RESP_STALL_EN
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fq_gnt_cycle%0d", k), 32'(gcyc_b[k] - t0), 32'(g_exp[k]));
            check($sformatf("fq_rvalid_cycle%0d", k), 32'(rcyc_b[k] - t0), 32'(r_exp[k]));
        end
`endif

        // Reset while the first of two responses is on the bus.
        issue(1, 1'b0, BASE_B + 32'h4, 4'h0, 32'h0);
        issue(1, 1'b0, BASE_B + 32'h8, 4'h0, 32'h0);
        t0 = gcyc_b[gcyc_b.size() - 1];
        while (cyc < t0 + LAT_B - 1) idle(1);
        #1;
        rst    = 1'b1;
        req[1] = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(rvalid[1]), 32'd0);
        check("async_rst_rdata", rdata[1], 32'd0);
        check("async_rst_gnt", 32'(gnt[1]), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        req[1] = 1'b0;
        idle(8);
        issue(1, 1'b0, BASE_B, 4'h0, 32'h0);
        idle(5);
        check("rst_persist", last_rd[1], fq_vals[0]);

        // Random traffic on both instances.
        fork
            rand_ops(0, 300);
            rand_ops(1, 300);
        join
        idle(8);

        // Back-to-back reads on the latency-1 instance.
        for (int k = 0; k < 1000; k++)
            issue(0, 1'b0, BASE_A + 4 * $urandom_range(0, 15), 4'h0, 32'h0);
        idle(10);

        check("rsp_count_a", 32'(n_rv_obs[0]), 32'(n_rsp_m[0]));
        check("rsp_count_b", 32'(n_rv_obs[1]), 32'(n_rsp_m[1]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
